inst_fetch_stage: RTL and testbench

//  IF stage of the MIPS 5-stage pipeline. Owns the PC and the ROM fetch handshake, and generates rom_stall for the pipeline controller.
//  It also holds the IF/ID pipeline register that feeds the ID-stage decoder/controller.
//  It applies the controller's pc_src redirects and its if/id enable/reset controls without ever breaking an outstanding ROM transaction.

---
 rtl/inst_fetch_stage_pkg.sv | 30 +++
 rtl/inst_fetch_stage_if.sv | 31 +++
 rtl/inst_fetch_stage_if_id_reg.sv | 81 ++++++++
 rtl/inst_fetch_stage.sv | 210 +++++++++++++++++++++
 tb/tb_inst_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_stage_pkg
//  Shared definitions for the MIPS IF stage:
//   - pc_src encodings driven by the pipeline controller
//   - IF fetch FSM state codes
//   - a helper that word-aligns redirect targets
// ---------------------------------------------------------------------------
package inst_fetch_stage_pkg;

   localparam logic [2:0] PC_NEXT     = 3'd0;
   localparam logic [2:0] PC_JUMP     = 3'd1;
   localparam logic [2:0] PC_BRANCH   = 3'd2;
   localparam logic [2:0] PC_FWD_DATA = 3'd3;
   localparam logic [2:0] PC_EPC      = 3'd4;

   localparam logic [31:0] INST_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_FETCH   = 2'd0,
      IF_HOLD    = 2'd1,
      IF_DISCARD = 2'd2
   } if_state_e;

   // Instruction addresses are always word aligned, so the two low bits of
   // any redirect target are simply cleared.
   function automatic logic [31:0] alignWord(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_stage_if
//  Instruction ROM fetch handshake.
//   rom_req   : fetch request, held until rom_ack
//   rom_addr  : fetch address, stable while rom_req && !rom_ack
//   rom_rdata : instruction word, valid together with rom_ack
//   rom_ack   : one-cycle completion pulse (may be in the first req cycle)
//  master = IF stage, slave = instruction ROM.
// ---------------------------------------------------------------------------
interface inst_fetch_stage_if;

   logic        rom_req;
   logic [31:0] rom_addr;
   logic [31:0] rom_rdata;
   logic        rom_ack;

   modport master (
      output rom_req,
      output rom_addr,
      input  rom_rdata,
      input  rom_ack
   );

   modport slave (
      input  rom_req,
      input  rom_addr,
      output rom_rdata,
      output rom_ack
   );

endinterface

// File: rtl/inst_fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// inst_fetch_stage_if_id_reg
//  IF/ID pipeline register feeding the ID-stage decoder.
//  Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : register load enable (low = hold everything)
//   flush_i    : synchronous flush, inserts a NOP (highest priority)
//   load_i     : the IF stage presents a fetched word this cycle
//   inst_i     : fetched instruction word
//   pc_i       : address of that instruction
//   inst_o     : instruction in ID
//   pc_o       : PC of inst_o
//   pc4_o      : pc_o + 4
//   valid_o    : inst_o is a real fetched instruction
// ---------------------------------------------------------------------------
module inst_fetch_stage_if_id_reg
   import inst_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] pc_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic        valid_o
);

   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_q,   pc_d;
   logic [31:0] pc4_q,  pc4_d;
   logic        valid_q, valid_d;

   // Next-state of the IF/ID register. A flush beats a hold, and a hold
   // beats a load. When the stage is enabled but IF has nothing to hand over
   // (ROM wait, discard, load stall) the old word stays visible but is
   // marked invalid, so ID sees a bubble rather than a repeated instruction.
   always_comb begin
      inst_d  = inst_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush_i) begin
         inst_d  = INST_NOP;
         valid_d = 1'b0;
      end else if (en_i) begin
         if (load_i) begin
            inst_d  = inst_i;
            pc_d    = pc_i;
            pc4_d   = pc_i + 32'd4;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // Register bank; reset leaves a NOP at PC 0 with its link value of 4.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q  <= INST_NOP;
         pc_q    <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0004;
         valid_q <= 1'b0;
      end else begin
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign inst_o  = inst_q;
   assign pc_o    = pc_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// ---------------------------------------------------------------------------
// inst_fetch_stage
//  IF stage of the MIPS 5-stage pipeline. Owns the PC, the ROM fetch
//  handshake and the IF/ID register, and reports rom_stall to the controller.
//  Parameters:
//   RESET_PC        : PC after reset or if_rst
//  Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   if_en_i         : IF advance enable
//   if_rst_i        : synchronous IF flush, restart at RESET_PC
//   id_en_i         : IF/ID load enable
//   id_rst_i        : synchronous IF/ID flush (NOP)
//   pc_src_i        : next-PC select (PC_NEXT/JUMP/BRANCH/FWD_DATA/EPC)
//   *_target_i      : redirect targets for each pc_src
//   rom             : ROM fetch handshake (master side)
//   rom_stall_o     : fetch not yet complete
//   inst_id_o       : instruction in ID
//   pc_id_o         : PC of inst_id_o
//   pc4_id_o        : pc_id_o + 4
//   id_valid_o      : inst_id_o is a real fetched instruction
// ---------------------------------------------------------------------------
module inst_fetch_stage
   import inst_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     if_en_i,
   input  logic                     if_rst_i,
   input  logic                     id_en_i,
   input  logic                     id_rst_i,
   input  logic [2:0]               pc_src_i,
   input  logic [31:0]              jump_target_i,
   input  logic [31:0]              branch_target_i,
   input  logic [31:0]              fwd_target_i,
   input  logic [31:0]              epc_target_i,
   inst_fetch_stage_if.master       rom,
   output logic                     rom_stall_o,
   output logic [31:0]              inst_id_o,
   output logic [31:0]              pc_id_o,
   output logic [31:0]              pc4_id_o,
   output logic                     id_valid_o
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] discAddr_q, discAddr_d;
   logic [31:0] holdWord_q, holdWord_d;
   logic        started_q;

   logic        redirect;
   logic [31:0] redirTarget;
   logic [31:0] npc;
   logic        romReq;
   logic        ackSeen;
   logic        idLoad;
   logic [31:0] idInst;

   // Next-PC selection. Unused pc_src codes behave like PC_NEXT so a stray
   // encoding can never throw the fetch stream into DISCARD.
   always_comb begin
      redirect    = 1'b0;
      redirTarget = pc_q;
      case (pc_src_i)
         PC_JUMP: begin
            redirect    = 1'b1;
            redirTarget = alignWord(jump_target_i);
         end
         PC_BRANCH: begin
            redirect    = 1'b1;
            redirTarget = alignWord(branch_target_i);
         end
         PC_FWD_DATA: begin
            redirect    = 1'b1;
            redirTarget = alignWord(fwd_target_i);
         end
         PC_EPC: begin
            redirect    = 1'b1;
            redirTarget = alignWord(epc_target_i);
         end
         default: begin
            redirect    = 1'b0;
            redirTarget = pc_q;
         end
      endcase
      npc = redirect ? redirTarget : (pc_q + 32'd4);
   end

   // ROM request side. The request stays off until the first clock after
   // reset; DISCARD keeps presenting the stale address so the ROM sees a
   // stable request until it acknowledges. The ack->stall path is purely
   // combinational so a zero-wait ROM never stalls the pipeline.
   always_comb begin
      romReq      = (started_q && (state_q == IF_FETCH)) || (state_q == IF_DISCARD);
      ackSeen     = romReq && rom.rom_ack;
      rom_stall_o = (started_q && (state_q == IF_FETCH) && !rom.rom_ack)
                  || (state_q == IF_DISCARD);
   end

   assign rom.rom_req  = romReq;
   assign rom.rom_addr = (state_q == IF_DISCARD) ? discAddr_q : pc_q;

   // Fetch FSM next-state logic. if_rst outranks any redirect; a request
   // already on the bus is never withdrawn, it is parked in DISCARD instead.
   // While a word waits in HOLD, pc_q still holds that word's address, so
   // it doubles as the held PC.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      discAddr_d = discAddr_q;
      holdWord_d = holdWord_q;
      idLoad     = 1'b0;
      idInst     = rom.rom_rdata;
      case (state_q)
         IF_FETCH: begin
            if (!started_q) begin
               if (if_rst_i) begin
                  pc_d = RESET_PC;
               end else if (redirect) begin
                  pc_d = redirTarget;
               end
            end else if (if_rst_i) begin
               pc_d       = RESET_PC;
               holdWord_d = INST_NOP;
               if (!ackSeen) begin
                  state_d    = IF_DISCARD;
                  discAddr_d = pc_q;
               end
            end else if (ackSeen) begin
               if (if_en_i) begin
                  idLoad = 1'b1;
                  idInst = rom.rom_rdata;
                  pc_d   = npc;
               end else if (redirect) begin
                  pc_d = redirTarget;
               end else begin
                  holdWord_d = rom.rom_rdata;
                  state_d    = IF_HOLD;
               end
            end else if (redirect) begin
               pc_d       = redirTarget;
               discAddr_d = pc_q;
               state_d    = IF_DISCARD;
            end
         end
         IF_HOLD: begin
            if (if_rst_i) begin
               pc_d       = RESET_PC;
               holdWord_d = INST_NOP;
               state_d    = IF_FETCH;
            end else if (if_en_i) begin
               idLoad  = 1'b1;
               idInst  = holdWord_q;
               pc_d    = npc;
               state_d = IF_FETCH;
            end else if (redirect) begin
               pc_d       = redirTarget;
               holdWord_d = INST_NOP;
               state_d    = IF_FETCH;
            end
         end
         IF_DISCARD: begin
            if (if_rst_i) begin
               pc_d = RESET_PC;
            end else if (redirect) begin
               pc_d = redirTarget;
            end
            if (ackSeen) begin
               state_d = IF_FETCH;
            end
         end
         default: begin
            state_d = IF_FETCH;
         end
      endcase
   end

   // State, PC and buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IF_FETCH;
         pc_q       <= RESET_PC;
         discAddr_q <= RESET_PC;
         holdWord_q <= INST_NOP;
         started_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         discAddr_q <= discAddr_d;
         holdWord_q <= holdWord_d;
         started_q  <= 1'b1;
      end
   end

   inst_fetch_stage_if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (id_en_i),
      .flush_i (id_rst_i),
      .load_i  (idLoad),
      .inst_i  (idInst),
      .pc_i    (pc_q),
      .inst_o  (inst_id_o),
      .pc_o    (pc_id_o),
      .pc4_o   (pc4_id_o),
      .valid_o (id_valid_o)
   );

endmodule

// File: tb/tb_inst_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_stage
//  Directed bench for inst_fetch_stage: a table of per-cycle vectors for
//  sequential fetch, ROM wait states and a jump into DISCARD, followed by
//  hand-written sequences for HOLD, PC wrap, target select, IF/ID controls,
//  async reset mid-wait and if_rst mid-wait.
// ---------------------------------------------------------------------------
module tb_inst_fetch_stage;
   import inst_fetch_stage_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ifEn, ifRst, idEn, idRst;
   logic [2:0]  pcSrc;
   logic [31:0] jumpTarget, branchTarget, fwdTarget, epcTarget;
   logic        romStall;
   logic [31:0] instId, pcId, pc4Id;
   logic        idValid;

   int checkCount;
   int passCount;

   inst_fetch_stage_if romBus();

   inst_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_en_i         (ifEn),
      .if_rst_i        (ifRst),
      .id_en_i         (idEn),
      .id_rst_i        (idRst),
      .pc_src_i        (pcSrc),
      .jump_target_i   (jumpTarget),
      .branch_target_i (branchTarget),
      .fwd_target_i    (fwdTarget),
      .epc_target_i    (epcTarget),
      .rom             (romBus.master),
      .rom_stall_o     (romStall),
      .inst_id_o       (instId),
      .pc_id_o         (pcId),
      .pc4_id_o        (pc4Id),
      .id_valid_o      (idValid)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic [2:0]  src;
      logic [31:0] jt;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expStall;
      logic [31:0] expInst;
      logic [31:0] expPc;
      logic [31:0] expPc4;
      logic        expValid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic ack, input logic [31:0] rdata,
                               input logic [2:0] src, input logic [31:0] jt,
                               input logic eReq, input logic [31:0] eAddr,
                               input logic eStall, input logic [31:0] eInst,
                               input logic [31:0] ePc, input logic [31:0] ePc4,
                               input logic eValid);
      vec_t v;
      v.ack = ack; v.rdata = rdata; v.src = src; v.jt = jt;
      v.expReq = eReq; v.expAddr = eAddr; v.expStall = eStall;
      v.expInst = eInst; v.expPc = ePc; v.expPc4 = ePc4; v.expValid = eValid;
      return v;
   endfunction

   // Single comparison; every check in the bench goes through here.
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic driveIn(input logic en, input logic ien, input logic irst,
                          input logic frst, input logic [2:0] src,
                          input logic ack, input logic [31:0] rdata);
      ifEn = en; idEn = ien; idRst = irst; ifRst = frst; pcSrc = src;
      romBus.rom_ack = ack; romBus.rom_rdata = rdata;
   endtask

   task automatic applyStimulus(input vec_t v);
      jumpTarget = v.jt;
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, v.src, v.ack, v.rdata);
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      checkVal({tag, ".rom_req"},   {31'b0, romBus.rom_req}, {31'b0, v.expReq});
      checkVal({tag, ".rom_addr"},  romBus.rom_addr, v.expAddr);
      checkVal({tag, ".rom_stall"}, {31'b0, romStall}, {31'b0, v.expStall});
      checkVal({tag, ".inst_id"},   instId, v.expInst);
      checkVal({tag, ".pc_id"},     pcId, v.expPc);
      checkVal({tag, ".pc4_id"},    pc4Id, v.expPc4);
      checkVal({tag, ".id_valid"},  {31'b0, idValid}, {31'b0, v.expValid});
   endtask

   task automatic checkBus(input string tag, input logic req, input logic [31:0] addr,
                           input logic stall);
      checkVal({tag, ".rom_req"},   {31'b0, romBus.rom_req}, {31'b0, req});
      checkVal({tag, ".rom_addr"},  romBus.rom_addr, addr);
      checkVal({tag, ".rom_stall"}, {31'b0, romStall}, {31'b0, stall});
   endtask

   task automatic checkId(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic valid);
      checkVal({tag, ".inst_id"},  instId, inst);
      checkVal({tag, ".pc_id"},    pcId, pc);
      checkVal({tag, ".pc4_id"},   pc4Id, pc4);
      checkVal({tag, ".id_valid"}, {31'b0, idValid}, {31'b0, valid});
   endtask

   // Main sequence. Every step starts at a falling edge: drive, settle 1,
   // compare, then wait for the next falling edge (one rising edge between).
   initial begin
      logic [2:0]  srcs [4];
      logic [31:0] expTgt [4];
      checkCount = 0;
      passCount  = 0;
      rst_n = 1'b0;
      jumpTarget = 32'h0; branchTarget = 32'h0; fwdTarget = 32'h0; epcTarget = 32'h0;
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b0, 32'h0);

      vecs.push_back(mk(1'b0, 32'h0, PC_NEXT, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0));
      vecs.push_back(mk(1'b1, 32'h1000_0000, PC_NEXT, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0));
      for (int k = 2; k <= 8; k++) begin
         vecs.push_back(mk(1'b1, 32'h1000_0000 | (4 * (k - 1)), PC_NEXT, 32'h0,
                           1'b1, 4 * (k - 1), 1'b0,
                           32'h1000_0000 | (4 * (k - 2)), 4 * (k - 2), 4 * (k - 2) + 4, 1'b1));
      end
      vecs.push_back(mk(1'b0, 32'h0, PC_NEXT, 32'h0, 1'b1, 32'h20, 1'b1, 32'h1000_001C, 32'h1C, 32'h20, 1'b1));
      vecs.push_back(mk(1'b0, 32'h0, PC_NEXT, 32'h0, 1'b1, 32'h20, 1'b1, 32'h1000_001C, 32'h1C, 32'h20, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0, PC_NEXT, 32'h0, 1'b1, 32'h20, 1'b1, 32'h1000_001C, 32'h1C, 32'h20, 1'b0));
      vecs.push_back(mk(1'b1, 32'h1000_0020, PC_NEXT, 32'h0, 1'b1, 32'h20, 1'b0, 32'h1000_001C, 32'h1C, 32'h20, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0, PC_JUMP, 32'h43, 1'b1, 32'h24, 1'b1, 32'h1000_0020, 32'h20, 32'h24, 1'b1));
      vecs.push_back(mk(1'b0, 32'h0, PC_NEXT, 32'h0, 1'b1, 32'h24, 1'b1, 32'h1000_0020, 32'h20, 32'h24, 1'b0));
      vecs.push_back(mk(1'b1, 32'hDEAD_BEEF, PC_NEXT, 32'h0, 1'b1, 32'h24, 1'b1, 32'h1000_0020, 32'h20, 32'h24, 1'b0));
      vecs.push_back(mk(1'b1, 32'h1000_0040, PC_NEXT, 32'h0, 1'b1, 32'h40, 1'b0, 32'h1000_0020, 32'h20, 32'h24, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0, PC_NEXT, 32'h0, 1'b1, 32'h44, 1'b1, 32'h1000_0040, 32'h40, 32'h44, 1'b1));

      repeat (2) @(negedge clk);
      #1;
      checkBus("reset", 1'b0, 32'h0, 1'b0);
      checkId("reset", 32'h0, 32'h0, 32'h4, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput(vecs[i], i);
         @(negedge clk);
      end

      // Load stall: word for 0x44 arrives with if_en low and parks in HOLD.
      driveIn(1'b0, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b1, 32'h1000_0044);
      #1; checkBus("hold.ack", 1'b1, 32'h44, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         driveIn(1'b0, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b0, 32'h0);
         #1;
         checkVal($sformatf("hold%0d.rom_req", i), {31'b0, romBus.rom_req}, 32'h0);
         checkVal($sformatf("hold%0d.rom_stall", i), {31'b0, romStall}, 32'h0);
         @(negedge clk);
      end
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b0, 32'h0);
      #1; checkVal("hold.release.rom_req", {31'b0, romBus.rom_req}, 32'h0);
      @(negedge clk);
      #1;
      checkBus("hold.after", 1'b1, 32'h48, 1'b1);
      checkId("hold.after", 32'h1000_0044, 32'h44, 32'h48, 1'b1);

      // PC wrap: jump to 0xFFFF_FFFF (aligned to ..FC), then sequential fetch.
      jumpTarget = 32'hFFFF_FFFF;
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_JUMP, 1'b1, 32'h1000_0048);
      @(negedge clk);
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b1, 32'h1234_5678);
      #1;
      checkBus("wrap.top", 1'b1, 32'hFFFF_FFFC, 1'b0);
      checkId("wrap.top", 32'h1000_0048, 32'h48, 32'h4C, 1'b1);
      @(negedge clk);
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b0, 32'h0);
      #1;
      checkBus("wrap.zero", 1'b1, 32'h0, 1'b1);
      checkId("wrap.zero", 32'h1234_5678, 32'hFFFF_FFFC, 32'h0, 1'b1);
      @(negedge clk);

      // Each redirect source selects its own target, low bits cleared.
      jumpTarget = 32'h103; branchTarget = 32'h202; fwdTarget = 32'h301; epcTarget = 32'h400;
      srcs[0] = PC_JUMP;  srcs[1] = PC_BRANCH; srcs[2] = PC_FWD_DATA; srcs[3] = PC_EPC;
      expTgt[0] = 32'h100; expTgt[1] = 32'h200; expTgt[2] = 32'h300; expTgt[3] = 32'h400;
      for (int i = 0; i < 4; i++) begin
         driveIn(1'b1, 1'b1, 1'b0, 1'b0, srcs[i], 1'b1, 32'hC0DE_0000 + i);
         @(negedge clk);
         #1;
         checkVal($sformatf("tgt%0d.rom_addr", i), romBus.rom_addr, expTgt[i]);
      end
      checkId("tgt.last", 32'hC0DE_0003, 32'h300, 32'h304, 1'b1);

      // IF/ID hold (id_en low) and flush (id_rst).
      driveIn(1'b1, 1'b0, 1'b0, 1'b0, PC_NEXT, 1'b1, 32'hAAAA_0400);
      @(negedge clk);
      #1;
      checkId("idhold", 32'hC0DE_0003, 32'h300, 32'h304, 1'b1);
      checkVal("idhold.rom_addr", romBus.rom_addr, 32'h404);
      driveIn(1'b1, 1'b1, 1'b1, 1'b0, PC_NEXT, 1'b1, 32'hBBBB_0404);
      @(negedge clk);
      #1;
      checkVal("idrst.inst_id", instId, 32'h0);
      checkVal("idrst.id_valid", {31'b0, idValid}, 32'h0);
      checkVal("idrst.rom_addr", romBus.rom_addr, 32'h408);

      // Async reset in the middle of a ROM wait.
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b0, 32'h0);
      @(negedge clk);
      #1; checkBus("wait", 1'b1, 32'h408, 1'b1);
      rst_n = 1'b0;
      #1;
      checkBus("rstmid", 1'b0, 32'h0, 1'b0);
      checkId("rstmid", 32'h0, 32'h0, 32'h4, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1; checkBus("rstrel", 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      #1; checkBus("rstfirst", 1'b1, 32'h0, 1'b1);

      // if_rst while the fetch of 0x80 is outstanding: ack is absorbed.
      jumpTarget = 32'h80;
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_JUMP, 1'b1, 32'h1000_0000);
      @(negedge clk);
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b0, 32'h0);
      #1; checkBus("ifrst.wait", 1'b1, 32'h80, 1'b1);
      @(negedge clk);
      driveIn(1'b1, 1'b1, 1'b0, 1'b1, PC_NEXT, 1'b0, 32'h0);
      @(negedge clk);
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b0, 32'h0);
      #1; checkBus("ifrst.disc", 1'b1, 32'h80, 1'b1);
      @(negedge clk);
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b1, 32'hBAD0_BAD0);
      #1; checkBus("ifrst.stale", 1'b1, 32'h80, 1'b1);
      @(negedge clk);
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b1, 32'h2000_0000);
      #1;
      checkBus("ifrst.refetch", 1'b1, 32'h0, 1'b0);
      checkId("ifrst.refetch", 32'h1000_0000, 32'h0, 32'h4, 1'b0);
      @(negedge clk);
      driveIn(1'b1, 1'b1, 1'b0, 1'b0, PC_NEXT, 1'b0, 32'h0);
      #1;
      checkId("ifrst.loaded", 32'h2000_0000, 32'h0, 32'h4, 1'b1);
      checkVal("ifrst.next.rom_addr", romBus.rom_addr, 32'h4);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
